// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus for the fetch stage.
// The fetch stage is the master: it drives the one-cycle request pulse and
// the address; memory answers with a one-cycle ack carrying the word.
interface instruction_fetch_if #(
  parameter int unsigned IWIDTH       = 32,
  parameter int unsigned AWIDTH_INSTR = 32
);
  logic                    f_o_syn;
  logic [AWIDTH_INSTR-1:0] f_o_addr_instr;
  logic [IWIDTH-1:0]       f_i_instr;
  logic                    f_i_ack;

  modport master (
    output f_o_syn,
    output f_o_addr_instr,
    input  f_i_instr,
    input  f_i_ack
  );

  modport slave (
    input  f_o_syn,
    input  f_o_addr_instr,
    output f_i_instr,
    output f_i_ack
  );
endinterface

// File: rtl/instruction_fetch.sv
// Front-end fetch stage: owns the fetch pointer, keeps at most one read in
// flight on the instruction-memory bus, and hands each returned word with
// its PC to the decoder. Handles downstream stall (one-entry skid buffer),
// ALU redirect and pipeline flush.
// Optional build macro FETCH_ALIGN_CHECK_EN: word-aligns redirect targets.
module instruction_fetch #(
  parameter int unsigned          IWIDTH       = 32,
  parameter int unsigned          AWIDTH_INSTR = 32,
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
  input  logic                f_clk,
  input  logic                f_rst,
  instruction_fetch_if.master mem,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_pc,
  output logic                f_o_ce,
  input  logic                f_i_ce,
  input  logic                f_i_stall,
  output logic                f_o_stall,
  input  logic                f_i_flush,
  output logic                f_o_flush,
  input  logic                f_change_pc,
  input  logic [PC_WIDTH-1:0] f_alu_pc_value
);

  // Request tracking: IDLE = nothing in flight, PEND = response expected,
  // DROP = response expected but must be discarded.
  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_DROP
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] ptr;
  logic                syn_q;
  logic                skid_valid;
  logic [IWIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;

  logic                pending;
  logic                drop;
  logic                accept;
  logic                issue;
  logic [PC_WIDTH-1:0] redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_pc = {f_alu_pc_value[PC_WIDTH-1:2], 2'b00};
`else
  assign redirect_pc = f_alu_pc_value;
`endif

  assign pending = (state != S_IDLE);
  assign drop    = (state == S_DROP);

  // Handshake decode: accept a live response, and decide whether a new
  // request may go out this cycle (back-to-back with an accept is allowed).
  always_comb begin
    accept = mem.f_i_ack & pending & ~drop;
    issue  = f_i_ce & ~f_i_stall & ~f_i_flush & ~f_change_pc & ~skid_valid
           & (~pending | accept);
  end

  assign f_o_stall   = f_i_stall | skid_valid | (pending & ~mem.f_i_ack);
  assign mem.f_o_syn = syn_q;

  if (AWIDTH_INSTR > PC_WIDTH) begin : g_addr_ext
    assign mem.f_o_addr_instr = {{(AWIDTH_INSTR-PC_WIDTH){1'b0}}, ptr};
  end else begin : g_addr_trunc
    assign mem.f_o_addr_instr = ptr[AWIDTH_INSTR-1:0];
  end

  // Fetch state machine: pointer, request pulse, outputs and skid buffer.
  always_ff @(posedge f_clk) begin
    if (!f_rst) begin
      state      <= S_IDLE;
      ptr        <= RESET_PC;
      syn_q      <= 1'b0;
      f_o_ce     <= 1'b0;
      f_o_flush  <= 1'b0;
      f_o_instr  <= '0;
      f_pc       <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      syn_q     <= issue;
      f_o_flush <= f_i_flush;
      if (f_change_pc) begin
        // A response landing in the redirect cycle is simply discarded.
        ptr        <= redirect_pc;
        f_o_ce     <= 1'b0;
        skid_valid <= 1'b0;
        state      <= (pending && !mem.f_i_ack) ? S_DROP : S_IDLE;
      end else if (f_i_flush) begin
        // Pointer is left alone so the discarded address is fetched again.
        f_o_ce     <= 1'b0;
        skid_valid <= 1'b0;
        state      <= (pending && !mem.f_i_ack) ? S_DROP : S_IDLE;
      end else begin
        if (issue) begin
          state <= S_PEND;
        end else if (pending && mem.f_i_ack) begin
          state <= S_IDLE;
        end

        if (accept) begin
          ptr <= ptr + PC_WIDTH'(4);
          if (!f_o_ce || !f_i_stall) begin
            f_o_instr <= mem.f_i_instr;
            f_pc      <= ptr;
            f_o_ce    <= 1'b1;
          end else begin
            skid_instr <= mem.f_i_instr;
            skid_pc    <= ptr;
            skid_valid <= 1'b1;
          end
        end else if (!f_i_stall) begin
          if (skid_valid) begin
            f_o_instr  <= skid_instr;
            f_pc       <= skid_pc;
            f_o_ce     <= 1'b1;
            skid_valid <= 1'b0;
          end else begin
            f_o_ce <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: zero-wait memory model returning
// 0x1000_0000 + addr/4, cycle-exact checks at each falling edge and an
// in-order delivery log compared against the expected PC stream.
module tb_instruction_fetch;

  logic        f_clk;
  logic        f_rst;
  logic [31:0] f_o_instr;
  logic [31:0] f_pc;
  logic        f_o_ce;
  logic        f_i_ce;
  logic        f_i_stall;
  logic        f_o_stall;
  logic        f_i_flush;
  logic        f_o_flush;
  logic        f_change_pc;
  logic [31:0] f_alu_pc_value;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];

  instruction_fetch_if #(.IWIDTH(32), .AWIDTH_INSTR(32)) bus ();

  instruction_fetch #(
    .IWIDTH      (32),
    .AWIDTH_INSTR(32),
    .PC_WIDTH    (32),
    .RESET_PC    (32'h0)
  ) dut (
    .f_clk         (f_clk),
    .f_rst         (f_rst),
    .mem           (bus),
    .f_o_instr     (f_o_instr),
    .f_pc          (f_pc),
    .f_o_ce        (f_o_ce),
    .f_i_ce        (f_i_ce),
    .f_i_stall     (f_i_stall),
    .f_o_stall     (f_o_stall),
    .f_i_flush     (f_i_flush),
    .f_o_flush     (f_o_flush),
    .f_change_pc   (f_change_pc),
    .f_alu_pc_value(f_alu_pc_value)
  );

  initial begin
    f_clk = 1'b0;
    forever #5 f_clk = ~f_clk;
  end

  // Memory: a request seen in one cycle is answered for exactly the next one.
  initial begin
    logic        pend_resp;
    logic [31:0] pend_word;
    pend_resp = 1'b0;
    pend_word = '0;
    bus.f_i_ack   = 1'b0;
    bus.f_i_instr = '0;
    forever begin
      @(posedge f_clk);
      #1;
      bus.f_i_ack   = pend_resp;
      bus.f_i_instr = pend_word;
      pend_resp     = bus.f_o_syn;
      pend_word     = 32'h1000_0000 + (bus.f_o_addr_instr >> 2);
    end
  end

  // Delivery log: an instruction is consumed when shown unstalled and not squashed.
  initial begin
    forever begin
      @(negedge f_clk);
      #1;
      if (f_rst && f_o_ce && !f_i_stall && !f_i_flush && !f_change_pc) begin
        got_pc.push_back(f_pc);
        got_in.push_back(f_o_instr);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic nx(input int unsigned n);
    repeat (n) @(negedge f_clk);
  endtask

  initial begin
    logic [31:0] exp_pc[9];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h100, 32'h104, 32'h108, 32'h10c, 32'h0};

    f_rst = 1'b0; f_i_ce = 1'b0; f_i_stall = 1'b0; f_i_flush = 1'b0;
    f_change_pc = 1'b0; f_alu_pc_value = '0;

    nx(2);  // t=20 after two reset edges
    chk("rst_syn",   32'(bus.f_o_syn), 32'd0);
    chk("rst_ce",    32'(f_o_ce), 32'd0);
    chk("rst_instr", f_o_instr, 32'h0);
    chk("rst_pc",    f_pc, 32'h0);
    chk("rst_addr",  bus.f_o_addr_instr, 32'h0);
    chk("rst_flush", 32'(f_o_flush), 32'd0);
    f_rst = 1'b1; f_i_ce = 1'b1;

    nx(1);  // t=30 first request out
    chk("req0_syn",   32'(bus.f_o_syn), 32'd1);
    chk("req0_addr",  bus.f_o_addr_instr, 32'h0);
    chk("req0_stall", 32'(f_o_stall), 32'd1);
    nx(1);  // t=40 ack on the bus
    chk("req0_pulse", 32'(bus.f_o_syn), 32'd0);
    chk("req0_ce",    32'(f_o_ce), 32'd0);
    nx(1);  // t=50 word 0 delivered, request for 4 out
    chk("d0_ce",    32'(f_o_ce), 32'd1);
    chk("d0_instr", f_o_instr, 32'h1000_0000);
    chk("d0_pc",    f_pc, 32'h0);
    chk("req1_syn", 32'(bus.f_o_syn), 32'd1);
    chk("req1_addr", bus.f_o_addr_instr, 32'h4);
    nx(1);  // t=60
    chk("d0_strobe", 32'(f_o_ce), 32'd0);
    nx(1);  // t=70
    chk("d1_ce",    32'(f_o_ce), 32'd1);
    chk("d1_instr", f_o_instr, 32'h1000_0001);
    chk("d1_pc",    f_pc, 32'h4);
    chk("req2_addr", bus.f_o_addr_instr, 32'h8);

    f_i_stall = 1'b1;
    nx(1);  // t=80 stalled, response for 8 still to come
    chk("st_ostall", 32'(f_o_stall), 32'd1);
    chk("st_syn",    32'(bus.f_o_syn), 32'd0);
    chk("st_ce",     32'(f_o_ce), 32'd1);
    chk("st_pc",     f_pc, 32'h4);
    nx(1);  // t=90 response parked in skid
    chk("skid_pc",    f_pc, 32'h4);
    chk("skid_instr", f_o_instr, 32'h1000_0001);
    chk("skid_stall", 32'(f_o_stall), 32'd1);
    nx(2);  // t=110 end of 4 stalled edges
    chk("st_end_pc",  f_pc, 32'h4);
    chk("st_end_syn", 32'(bus.f_o_syn), 32'd0);
    chk("st_end_ce",  32'(f_o_ce), 32'd1);
    f_i_stall = 1'b0;
    nx(1);  // t=120 skid drained
    chk("unst_ce",    32'(f_o_ce), 32'd1);
    chk("unst_pc",    f_pc, 32'h8);
    chk("unst_instr", f_o_instr, 32'h1000_0002);
    chk("unst_syn",   32'(bus.f_o_syn), 32'd0);
    chk("unst_stall", 32'(f_o_stall), 32'd0);
    nx(1);  // t=130
    chk("req3_syn",  32'(bus.f_o_syn), 32'd1);
    chk("req3_addr", bus.f_o_addr_instr, 32'hc);
    chk("req3_ce",   32'(f_o_ce), 32'd0);
    nx(2);  // t=150
    chk("d3_ce",    32'(f_o_ce), 32'd1);
    chk("d3_pc",    f_pc, 32'hc);
    chk("d3_instr", f_o_instr, 32'h1000_0003);
    chk("req4_addr", bus.f_o_addr_instr, 32'h10);
    nx(1);  // t=160 ack for 0x10 on the bus: redirect in the same cycle
    f_change_pc = 1'b1; f_alu_pc_value = 32'h200;
    nx(1);  // t=170
    f_change_pc = 1'b0;
    chk("rdA_addr",  bus.f_o_addr_instr, 32'h200);
    chk("rdA_syn",   32'(bus.f_o_syn), 32'd0);
    chk("rdA_ce",    32'(f_o_ce), 32'd0);
    chk("rdA_stall", 32'(f_o_stall), 32'd0);
    nx(1);  // t=180
    chk("rdA_req_syn",  32'(bus.f_o_syn), 32'd1);
    chk("rdA_req_addr", bus.f_o_addr_instr, 32'h200);
    nx(2);  // t=200
    chk("dA_ce",    32'(f_o_ce), 32'd1);
    chk("dA_pc",    f_pc, 32'h200);
    chk("dA_instr", f_o_instr, 32'h1000_0080);
    chk("reqA1_addr", bus.f_o_addr_instr, 32'h204);
    // Redirect while 0x204 is pending and its ack has not arrived.
    f_change_pc = 1'b1; f_alu_pc_value = 32'h100;
    nx(1);  // t=210
    f_change_pc = 1'b0;
    chk("rdB_addr", bus.f_o_addr_instr, 32'h100);
    chk("rdB_syn",  32'(bus.f_o_syn), 32'd0);
    chk("rdB_ce",   32'(f_o_ce), 32'd0);
    nx(1);  // t=220 dropped response must not appear
    chk("drop_ce",  32'(f_o_ce), 32'd0);
    chk("drop_syn", 32'(bus.f_o_syn), 32'd0);
    nx(1);  // t=230
    chk("rdB_req_syn",  32'(bus.f_o_syn), 32'd1);
    chk("rdB_req_addr", bus.f_o_addr_instr, 32'h100);
    nx(2);  // t=250
    chk("dB0_pc",    f_pc, 32'h100);
    chk("dB0_instr", f_o_instr, 32'h1000_0040);
    chk("reqB1_addr", bus.f_o_addr_instr, 32'h104);
    nx(2);  // t=270
    chk("dB1_ce", 32'(f_o_ce), 32'd1);
    chk("dB1_pc", f_pc, 32'h104);
    chk("reqB2_addr", bus.f_o_addr_instr, 32'h108);
    nx(1);  // t=280 ack for 0x108 arriving: flush for two cycles
    f_i_flush = 1'b1;
    nx(1);  // t=290
    chk("fl1_oflush", 32'(f_o_flush), 32'd1);
    chk("fl1_ce",     32'(f_o_ce), 32'd0);
    chk("fl1_syn",    32'(bus.f_o_syn), 32'd0);
    chk("fl1_addr",   bus.f_o_addr_instr, 32'h108);
    nx(1);  // t=300
    f_i_flush = 1'b0;
    chk("fl2_oflush", 32'(f_o_flush), 32'd1);
    chk("fl2_syn",    32'(bus.f_o_syn), 32'd0);
    nx(1);  // t=310
    chk("fl3_oflush", 32'(f_o_flush), 32'd0);
    chk("refetch_syn",  32'(bus.f_o_syn), 32'd1);
    chk("refetch_addr", bus.f_o_addr_instr, 32'h108);
    nx(2);  // t=330
    chk("dB2_pc",    f_pc, 32'h108);
    chk("dB2_instr", f_o_instr, 32'h1000_0042);
    f_i_ce = 1'b0;
    nx(2);  // t=350 outstanding 0x10c completes with fetch disabled
    chk("ce0_ce",    32'(f_o_ce), 32'd1);
    chk("ce0_pc",    f_pc, 32'h10c);
    chk("ce0_instr", f_o_instr, 32'h1000_0043);
    chk("ce0_syn",   32'(bus.f_o_syn), 32'd0);
    nx(1);  // t=360
    chk("ce0_idle_syn",   32'(bus.f_o_syn), 32'd0);
    chk("ce0_idle_addr",  bus.f_o_addr_instr, 32'h110);
    chk("ce0_idle_stall", 32'(f_o_stall), 32'd0);
    f_i_ce = 1'b1;
    nx(1);  // t=370 request for 0x110 in flight, then reset
    chk("pre_rst_syn",   32'(bus.f_o_syn), 32'd1);
    chk("pre_rst_stall", 32'(f_o_stall), 32'd1);
    f_rst = 1'b0;
    nx(1);  // t=380 late ack on the bus now
    chk("mrst_syn",   32'(bus.f_o_syn), 32'd0);
    chk("mrst_addr",  bus.f_o_addr_instr, 32'h0);
    chk("mrst_ce",    32'(f_o_ce), 32'd0);
    chk("mrst_instr", f_o_instr, 32'h0);
    chk("mrst_pc",    f_pc, 32'h0);
    chk("mrst_stall", 32'(f_o_stall), 32'd0);
    f_rst = 1'b1;
    nx(1);  // t=390 late ack ignored, fresh request from 0
    chk("late_ce",   32'(f_o_ce), 32'd0);
    chk("late_syn",  32'(bus.f_o_syn), 32'd1);
    chk("late_addr", bus.f_o_addr_instr, 32'h0);
    nx(2);  // t=410
    chk("post_ce",    32'(f_o_ce), 32'd1);
    chk("post_pc",    f_pc, 32'h0);
    chk("post_instr", f_o_instr, 32'h1000_0000);
    nx(1);  // t=420
    f_i_ce = 1'b0;

    chk("n_delivered", 32'(got_pc.size()), 32'd9);
    for (int i = 0; i < 9 && i < got_pc.size(); i++) begin
      chk($sformatf("seq_pc[%0d]", i), got_pc[i], exp_pc[i]);
      chk($sformatf("seq_instr[%0d]", i), got_in[i], 32'h1000_0000 + (exp_pc[i] >> 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
